kbd_game_key_decoder: RTL



---
 rtl/kbd_game_key_decoder_pkg.sv | 27 ++
 rtl/kbd_game_key_decoder_if.sv | 20 ++
 rtl/kbd_game_key_decoder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/kbd_game_key_decoder_pkg.sv
// -----------------------------------------------------------------------------
// kbd_pkg
// Shared types and constants for the PS/2 set-2 game key decoder:
//   - state_t      : prefix-tracking FSM states
//   - PREFIX_EXT   : extended-key prefix byte (E0)
//   - PREFIX_BRK   : break (key release) prefix byte (F0)
//   - DEF_*_CODE   : default scan codes of the three tracked keys
// -----------------------------------------------------------------------------
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_E0   = 2'd1,
    GOT_F0   = 2'd2,
    GOT_E0F0 = 2'd3
  } state_t;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  localparam logic [7:0] DEF_SPACE_CODE = 8'h29;  // non-extended
  localparam logic [7:0] DEF_LEFT_CODE  = 8'h6B;  // E0-prefixed
  localparam logic [7:0] DEF_RIGHT_CODE = 8'h74;  // E0-prefixed

  localparam int unsigned DEF_TIMEOUT_CYCLES = 100000;  // 2 ms at 50 MHz

endpackage : kbd_pkg

// File: rtl/kbd_game_key_decoder_if.sv
// -----------------------------------------------------------------------------
// kbd_game_key_decoder_if
// Scan-byte stream from the PS/2 byte receiver to the key decoder.
//   byteValid : one-cycle strobe, byteData holds a received scan byte
//   byteData  : scan-code byte, valid while byteValid=1
//   byteErr   : one-cycle strobe, receiver dropped a byte (parity/framing)
// Modports:
//   master : byte receiver side (drives the stream)
//   slave  : decoder side (consumes the stream)
// -----------------------------------------------------------------------------
interface kbd_game_key_decoder_if;

  logic       byteValid;
  logic [7:0] byteData;
  logic       byteErr;

  modport master (output byteValid, output byteData, output byteErr);
  modport slave  (input  byteValid, input  byteData, input  byteErr);

endinterface : kbd_game_key_decoder_if

// File: rtl/kbd_game_key_decoder.sv
// -----------------------------------------------------------------------------
// kbd_game_key_decoder
// Turns the PS/2 set-2 scan-byte stream into held-key levels and edge pulses
// for the game controller. A four-state FSM tracks the E0 (extended) and F0
// (break) prefixes.
//
// Ports:
//   clk        : system clock
//   resetN     : asynchronous active-low reset
//   byte_if    : scan-byte stream (slave modport: byteValid, byteData, byteErr)
//   clearKeys  : synchronous clear of all key state
//   rightArrow : right arrow held (level)
//   leftArrow  : left arrow held (level)
//   spaceBar   : space bar held (level)
//   spacePress : one-cycle pulse on a space make while spaceBar was 0
//   keyEvent   : one-cycle pulse whenever a tracked key level changes
//
// Optional feature (macro KBD_PREFIX_TIMEOUT_EN):
//   A pending prefix is abandoned after TIMEOUT_CYCLES cycles without a byte.
//   Without the macro a prefix waits indefinitely for the next byte.
//
// Outputs change one edge after the byte is accepted. Typematic repeats and
// breaks of keys that are not held change no level and raise no pulse.
// -----------------------------------------------------------------------------
module kbd_game_key_decoder
  import kbd_pkg::*;
#(
  parameter logic [7:0]  SPACE_CODE     = DEF_SPACE_CODE,
  parameter logic [7:0]  LEFT_CODE      = DEF_LEFT_CODE,
  parameter logic [7:0]  RIGHT_CODE     = DEF_RIGHT_CODE,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   resetN,
  kbd_game_key_decoder_if.slave  byte_if,
  input  logic                   clearKeys,
  output logic                   rightArrow,
  output logic                   leftArrow,
  output logic                   spaceBar,
  output logic                   spacePress,
  output logic                   keyEvent
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t state;

`ifdef KBD_PREFIX_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] idle_cnt;
`endif

  // NOTE: all state below is sequential and assigned with <= so every branch
  // sees the pre-edge values of spaceBar/leftArrow/rightArrow.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      rightArrow <= 1'b0;
      leftArrow  <= 1'b0;
      spaceBar   <= 1'b0;
      spacePress <= 1'b0;
      keyEvent   <= 1'b0;
`ifdef KBD_PREFIX_TIMEOUT_EN
      idle_cnt   <= '0;
`endif
    end else begin
      // NOTE: pulses default low each cycle; a branch below raises them for
      // exactly one clock.
      spacePress <= 1'b0;
      keyEvent   <= 1'b0;
`ifdef KBD_PREFIX_TIMEOUT_EN
      idle_cnt   <= '0;
`endif

      if (clearKeys) begin
        state      <= IDLE;
        rightArrow <= 1'b0;
        leftArrow  <= 1'b0;
        spaceBar   <= 1'b0;
      end else if (byte_if.byteErr) begin
        // A lost byte may have been a prefix or a code; drop any context.
        state <= IDLE;
      end else if (byte_if.byteValid) begin
        unique case (state)
          IDLE: begin
            if (byte_if.byteData == PREFIX_EXT) begin
              state <= GOT_E0;
            end else if (byte_if.byteData == PREFIX_BRK) begin
              state <= GOT_F0;
            end else if (byte_if.byteData == SPACE_CODE && !spaceBar) begin
              spaceBar   <= 1'b1;
              spacePress <= 1'b1;
              keyEvent   <= 1'b1;
            end
          end

          GOT_E0: begin
            if (byte_if.byteData == PREFIX_BRK) begin
              state <= GOT_E0F0;
            end else if (byte_if.byteData != PREFIX_EXT) begin
              state <= IDLE;
              if (byte_if.byteData == LEFT_CODE && !leftArrow) begin
                leftArrow <= 1'b1;
                keyEvent  <= 1'b1;
              end
              if (byte_if.byteData == RIGHT_CODE && !rightArrow) begin
                rightArrow <= 1'b1;
                keyEvent   <= 1'b1;
              end
            end
          end

          GOT_F0: begin
            if (byte_if.byteData == PREFIX_EXT) begin
              state <= GOT_E0;
            end else if (byte_if.byteData != PREFIX_BRK) begin
              state <= IDLE;
              if (byte_if.byteData == SPACE_CODE && spaceBar) begin
                spaceBar <= 1'b0;
                keyEvent <= 1'b1;
              end
            end
          end

          GOT_E0F0: begin
            state <= IDLE;
            if (byte_if.byteData == LEFT_CODE && leftArrow) begin
              leftArrow <= 1'b0;
              keyEvent  <= 1'b1;
            end
            if (byte_if.byteData == RIGHT_CODE && rightArrow) begin
              rightArrow <= 1'b0;
              keyEvent   <= 1'b1;
            end
          end

          default: state <= IDLE;
        endcase
`ifdef KBD_PREFIX_TIMEOUT_EN
      end else if (state != IDLE) begin
        // Counts idle cycles spent holding a prefix; the last one abandons it.
        if (idle_cnt == CNT_LAST) begin
          state <= IDLE;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
`endif
      end
    end
  end

endmodule : kbd_game_key_decoder
